nibble_seq_adder: RTL and testbench

//  Multi-cycle wide adder wrapped around the existing 4-bit ex2 adder (a, b, cin -> s, cout).

---
 rtl/nibble_seq_pkg.sv | 12 +
 rtl/ex2.sv | 18 +
 rtl/nibble_seq_adder.sv | 102 ++++++++++
 tb/tb_nibble_seq_adder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/nibble_seq_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
package nibble_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ex2.sv
// Existing 4-bit adder slice: {cout, s} = a + b + cin.
module ex2
  import nibble_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
  assign s      = w_full[NIB_W-1:0];
  assign cout   = w_full[NIB_W];

endmodule

// File: rtl/nibble_seq_adder.sv
// Wide adder built by feeding ex2 one nibble per clock, LSB first, with a carry flop.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | adding nibble r_idx, one per clock
//   DONE  | one-cycle result strobe; start here re-launches without a bubble
module nibble_seq_adder
  import nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NIB_W*NIBBLES-1:0] op_a,
  input  logic [NIB_W*NIBBLES-1:0] op_b,
  input  logic                     cin,
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] sum,
  output logic                     cout
);

  localparam int W  = NIB_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_op_a;
  logic [W-1:0]    r_op_b;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic            r_cout;
  logic [IW-1:0]   r_idx;

  logic            w_accept;
  logic            w_last;
  logic [NIB_W-1:0] w_nib_a;
  logic [NIB_W-1:0] w_nib_b;
  logic [NIB_W-1:0] w_s;
  logic            w_co;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_idx == IW'(NIBBLES - 1));
  assign w_nib_a  = r_op_a[NIB_W*r_idx +: NIB_W];
  assign w_nib_b  = r_op_b[NIB_W*r_idx +: NIB_W];

  ex2 u_ex2 (
    .a    (w_nib_a),
    .b    (w_nib_b),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_op_a  <= op_a;
      r_op_b  <= op_b;
      r_carry <= cin;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == RUN) begin
      // top nibble's carry becomes the visible cout; lower ones only feed the flop
      r_sum[NIB_W*r_idx +: NIB_W] <= w_s;
      r_carry <= w_co;
      r_idx   <= r_idx + IW'(1);
      if (w_last) r_cout <= w_co;
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_nibble_seq_adder.sv
// Directed and random checks of nibble_seq_adder (NIBBLES=4 and NIBBLES=1) against an arithmetic model.
module tb_nibble_seq_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start4 = 1'b0;
  logic        start1 = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;

  logic        busy4, done4, cout4;
  logic [15:0] sum4;
  logic        busy1, done1, cout1;
  logic [3:0]  sum1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nibble_seq_adder #(.NIBBLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  nibble_seq_adder #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a[3:0]), .op_b(op_b[3:0]), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // {cout,sum} = a + b + cin over a W-bit operand, kept to W+1 bits
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input int nib);
    longint mask_w, mask_r, t;
    mask_w = (64'sd1 <<< (4 * nib)) - 64'sd1;
    mask_r = (64'sd1 <<< (4 * nib + 1)) - 64'sd1;
    t = (longint'(a) & mask_w) + (longint'(b) & mask_w) + longint'(ci);
    return 17'(t & mask_r);
  endfunction

  function automatic logic [16:0] observed(input bit s);
    return s ? {12'b0, cout1, sum1} : {cout4, sum4};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit s, input logic [15:0] a, input logic [15:0] b, input logic ci);
    op_a = a;
    op_b = b;
    cin  = ci;
    if (s) start1 = 1'b1;
    else   start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  // Entered at the n0-th negedge after the accepting edge; returns at the done negedge.
  task automatic wait_check(input string tag, input bit s, input logic [15:0] a,
                            input logic [15:0] b, input logic ci, input int n0);
    int n;
    int busy_n;
    int nib;
    bit seen;
    n = n0;
    busy_n = n0 - 1;
    nib = s ? 1 : 4;
    seen = 1'b0;
    while (n <= 40) begin
      if (s ? done1 : done4) begin
        seen = 1'b1;
        break;
      end
      if (s ? busy1 : busy4) busy_n++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'(1));
    chk({tag, "_latency"}, 64'(n), 64'(nib + 1));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(nib));
    chk({tag, "_result"}, 64'(observed(s)), 64'(model(a, b, ci, nib)));
  endtask

  task automatic check_idle(input string tag, input bit s, input logic [16:0] exp);
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, 64'(s ? done1 : done4), 64'(0));
    chk({tag, "_busy_idle"}, 64'(s ? busy1 : busy4), 64'(0));
    chk({tag, "_result_held"}, 64'(observed(s)), 64'(exp));
  endtask

  initial begin
    int dn;
    logic [15:0] ra, rb;
    logic rc;
    bit rs;

    #12;
    chk("reset_busy4", 64'(busy4), 64'(0));
    chk("reset_done4", 64'(done4), 64'(0));
    chk("reset_result4", 64'(observed(1'b0)), 64'(0));
    chk("reset_result1", 64'(observed(1'b1)), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 16'h0005, 16'h0004, 1'b0);
    wait_check("basic", 1'b0, 16'h0005, 16'h0004, 1'b0, 1);
    chk("basic_value", 64'(observed(1'b0)), 64'h9);
    check_idle("basic", 1'b0, 17'h00009);

    issue(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    wait_check("ripple", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1);
    check_idle("ripple", 1'b0, 17'h10000);

    issue(1'b0, 16'h1234, 16'h4321, 1'b1);
    wait_check("carry_in", 1'b0, 16'h1234, 16'h4321, 1'b1, 1);
    chk("carry_in_value", 64'(observed(1'b0)), 64'h5556);

    issue(1'b0, 16'h8000, 16'h8000, 1'b0);
    wait_check("overflow", 1'b0, 16'h8000, 16'h8000, 1'b0, 1);
    check_idle("overflow", 1'b0, 17'h10000);

    // start during RUN with different operands must be ignored
    issue(1'b0, 16'h0102, 16'h0304, 1'b0);
    op_a = 16'h1111;
    cin = 1'b1;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_check("ign_start", 1'b0, 16'h0102, 16'h0304, 1'b0, 2);
    check_idle("ign_start", 1'b0, 17'h00406);

    issue(1'b0, 16'h1000, 16'h2000, 1'b0);
    wait_check("b2b_first", 1'b0, 16'h1000, 16'h2000, 1'b0, 1);
    issue(1'b0, 16'h0003, 16'h0009, 1'b1);
    wait_check("b2b_second", 1'b0, 16'h0003, 16'h0009, 1'b1, 1);
    chk("b2b_value", 64'(observed(1'b0)), 64'hD);
    check_idle("b2b", 1'b0, 17'h0000D);

    // reset asserted in the 2nd RUN cycle aborts the operation
    issue(1'b0, 16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy4), 64'(0));
    chk("rst_mid_done", 64'(done4), 64'(0));
    chk("rst_mid_result", 64'(observed(1'b0)), 64'(0));
    dn = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done4) dn++;
      if (k == 2) rst_n = 1'b1;
    end
    chk("rst_mid_no_done", 64'(dn), 64'(0));
    chk("rst_mid_idle", 64'(busy4), 64'(0));

    issue(1'b1, 16'h0008, 16'h0009, 1'b0);
    wait_check("nib1_a", 1'b1, 16'h0008, 16'h0009, 1'b0, 1);
    chk("nib1_a_value", 64'(observed(1'b1)), 64'h11);
    check_idle("nib1_a", 1'b1, 17'h00011);
    issue(1'b1, 16'h0005, 16'h0004, 1'b1);
    wait_check("nib1_b", 1'b1, 16'h0005, 16'h0004, 1'b1, 1);
    chk("nib1_b_value", 64'(observed(1'b1)), 64'hA);
    check_idle("nib1_b", 1'b1, 17'h0000A);

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = (i % 4 == 3);
      issue(rs, ra, rb, rc);
      wait_check($sformatf("rand%0d", i), rs, ra, rb, rc, 1);
      if ($urandom_range(1, 0) == 1) check_idle($sformatf("rand%0d", i), rs, model(ra, rb, rc, rs ? 1 : 4));
    end
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
